// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM line arbiter: line geometry and
// the transfer sequencer state encoding.
package sram_arb_pkg;

    localparam int LINE_BEATS = 4;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 128;
    localparam int BEAT_W     = $clog2(LINE_BEATS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } arbState_t;

    // A single requester still needs a one-bit index register.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_line_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search begins one position after the
// previous winner and wraps, so every requester eventually gets a turn.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idxWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid
);

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_valid && req[j] &&
                    (j == ((int'(last_grant) + k) % NUM_REQ))) begin
                    grant[j]    = 1'b1;
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_line_arbiter.sv
// Shares one 32-bit OpenRAM port between line requesters and the program
// loader; each granted 128-bit line moves as four word beats.
module sram_line_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*LINE_W-1:0] wr_data,
    output logic [LINE_W-1:0]         rd_data_out,
    output logic [NUM_REQ-1:0]        ready,
    input  logic                      is_loading_memory_into_core,
    input  logic [ADDR_W-1:0]         addr_to_core_mem,
    input  logic [WORD_W-1:0]         data_to_core_mem,
    output logic                      busy,
    output logic                      csb0_to_sram,
    output logic                      we_to_sram,
    output logic                      spare_wen0_to_sram,
    output logic [ADDR_W-1:0]         addr0_to_sram,
    output logic [WORD_W-1:0]         din0_to_sram,
    input  logic [WORD_W-1:0]         dout0_to_sram
);

    localparam int IDX_W = idxWidth(NUM_REQ);
    localparam int LA_W  = ADDR_W - 4;

    arbState_t          r_state;
    arbState_t          w_nextState;
    logic [BEAT_W-1:0]  r_beat;
    logic [IDX_W-1:0]   r_winner;
    logic [IDX_W-1:0]   r_lastGrant;
    logic [LA_W-1:0]    r_addrLine;
    logic [LINE_W-1:0]  r_rdData;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_grantValid;
    logic [IDX_W-1:0]   w_grantIdx;
    logic               w_start;
    logic [LINE_W-1:0]  w_wrLine;
    logic [WORD_W-1:0]  w_wrWord;
    logic [BEAT_W-1:0]  w_capWord;
    logic [ADDR_W-1:0]  w_beatAddr;
    logic               w_unusedAddrBits;

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rrArbiter (
        .req         (req),
        .last_grant  (r_lastGrant),
        .grant       (w_grant),
        .grant_valid (w_grantValid)
    );

    always_comb begin
        w_grantIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grantIdx = IDX_W'(i);
            end
        end
    end

    // Byte-offset bits within a line never reach the SRAM.
    always_comb begin
        w_unusedAddrBits = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_unusedAddrBits ^= ^addr_in[i*ADDR_W +: 4];
        end
    end

    // The loader owns the port whenever the sequencer is idle.
    assign w_start    = (r_state == ST_IDLE) && !is_loading_memory_into_core && w_grantValid;
    assign w_wrLine   = wr_data[int'(r_winner)*LINE_W +: LINE_W];
    assign w_wrWord   = w_wrLine[int'(r_beat)*WORD_W +: WORD_W];
    assign w_capWord  = r_beat - 1'b1;
    assign w_beatAddr = {2'b00, r_addrLine, r_beat};

    assign busy               = (r_state != ST_IDLE);
    assign rd_data_out        = r_rdData;
    assign spare_wen0_to_sram = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        csb0_to_sram  = 1'b1;
        we_to_sram    = 1'b1;
        addr0_to_sram = '0;
        din0_to_sram  = '0;
        ready         = '0;
        case (r_state)
            ST_IDLE: begin
                if (is_loading_memory_into_core) begin
                    csb0_to_sram  = 1'b0;
                    we_to_sram    = 1'b0;
                    addr0_to_sram = addr_to_core_mem;
                    din0_to_sram  = data_to_core_mem;
                end
                if (w_start) begin
                    w_nextState = we[w_grantIdx] ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                csb0_to_sram  = 1'b0;
                we_to_sram    = 1'b0;
                addr0_to_sram = w_beatAddr;
                din0_to_sram  = w_wrWord;
                if (r_beat == BEAT_W'(LINE_BEATS - 1)) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_READ: begin
                csb0_to_sram  = 1'b0;
                addr0_to_sram = w_beatAddr;
                if (r_beat == BEAT_W'(LINE_BEATS - 1)) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    ready[i] = (r_winner == IDX_W'(i));
                end
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // SRAM data lags the access edge by one cycle, so word b-1 lands during beat b.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_beat      <= '0;
            r_winner    <= '0;
            r_lastGrant <= IDX_W'(NUM_REQ - 1);
            r_addrLine  <= '0;
            r_rdData    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_beat      <= '0;
                        r_winner    <= w_grantIdx;
                        r_lastGrant <= w_grantIdx;
                        r_addrLine  <= addr_in[int'(w_grantIdx)*ADDR_W + 4 +: LA_W];
                    end
                end
                ST_WRITE: begin
                    r_beat <= r_beat + 1'b1;
                end
                ST_READ: begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat != '0) begin
                        r_rdData[int'(w_capWord)*WORD_W +: WORD_W] <= dout0_to_sram;
                    end
                end
                ST_DRAIN: begin
                    r_rdData[(LINE_BEATS-1)*WORD_W +: WORD_W] <= dout0_to_sram;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_line_arbiter.sv
// Randomized bench for sram_line_arbiter: a transaction-level model predicts
// every cycle of port activity, ready pulses and returned line data.
module tb_sram_line_arbiter;

    localparam int N  = 2;
    localparam int AW = 20;

    localparam int K_BEAT  = 0;
    localparam int K_DRAIN = 1;
    localparam int K_DONE  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      weLine;
    logic [N*AW-1:0]   addrIn;
    logic [N*128-1:0]  wrData;
    logic [127:0]      rdDataOut;
    logic [N-1:0]      ready;
    logic              loadActive;
    logic [AW-1:0]     loadAddr;
    logic [31:0]       loadData;
    logic              busy;
    logic              csb0;
    logic              weSram;
    logic              spareWen;
    logic [AW-1:0]     addr0;
    logic [31:0]       din0;
    logic [31:0]       dout0;

    always #5 clk = ~clk;

    sram_line_arbiter #(
        .NUM_REQ                     (N),
        .ADDR_W                      (AW)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .req                         (req),
        .we                          (weLine),
        .addr_in                     (addrIn),
        .wr_data                     (wrData),
        .rd_data_out                 (rdDataOut),
        .ready                       (ready),
        .is_loading_memory_into_core (loadActive),
        .addr_to_core_mem            (loadAddr),
        .data_to_core_mem            (loadData),
        .busy                        (busy),
        .csb0_to_sram                (csb0),
        .we_to_sram                  (weSram),
        .spare_wen0_to_sram          (spareWen),
        .addr0_to_sram               (addr0),
        .din0_to_sram                (din0),
        .dout0_to_sram               (dout0)
    );

    // Behavioural SRAM: read data appears the cycle after the access edge.
    logic [31:0] sramMem [0:255];

    always @(posedge clk) begin
        if (!csb0) begin
            if (!weSram) begin
                sramMem[addr0[7:0]] <= din0;
            end else begin
                dout0 <= sramMem[addr0[7:0]];
            end
        end
    end

    typedef struct {
        int       kind;
        bit       isWrite;
        int       wordAddr;
        bit [31:0] din;
        int       who;
        int       line;
    } expRec_t;

    expRec_t      expQ[$];
    bit [31:0]    goldMem [0:255];
    logic [127:0] expRd;
    int           modelLast;
    bit           pending [N];
    bit           active  [N];
    int           reqProb;
    int           loadProb;
    int           dropProb;
    int           passCount;
    int           checkCount;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: observed %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [127:0] lineFromGold(input int line);
        logic [127:0] l;
        for (int b = 0; b < 4; b++) begin
            l[b*32 +: 32] = goldMem[(line*4 + b) & 255];
        end
        return l;
    endfunction

    function automatic bit anyPending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) begin
            p |= pending[i];
        end
        return p;
    endfunction

    task automatic startReq(input int i, input bit isWr, input logic [AW-1:0] a,
                            input logic [127:0] d);
        req[i]               = 1'b1;
        weLine[i]            = isWr;
        addrIn[i*AW +: AW]   = a;
        wrData[i*128 +: 128] = d;
        pending[i]           = 1'b1;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!pending[i]) begin
                if ($urandom_range(0, 99) < reqProb) begin
                    startReq(i, 1'($urandom_range(0, 1)),
                             AW'($urandom_range(0, 63) * 16 + $urandom_range(0, 15)),
                             {$urandom, $urandom, $urandom, $urandom});
                end else begin
                    req[i] = 1'b0;
                end
            end else if (active[i] && ($urandom_range(0, 99) < dropProb)) begin
                req[i] = 1'b0;
            end
        end
        if (loadProb > 0) begin
            loadActive = ($urandom_range(0, 99) < loadProb);
            loadAddr   = AW'($urandom_range(0, 255));
            loadData   = $urandom;
        end
    endtask

    task automatic modelCheck();
        expRec_t r;
        if (expQ.size() == 0) begin
            checkOutput("idleBusy", busy, 0);
            checkOutput("idleReady", ready, 0);
            checkOutput("rdHold", rdDataOut, expRd);
            checkOutput("spareWen", spareWen, 1);
            if (loadActive) begin
                checkOutput("loadCsb", csb0, 0);
                checkOutput("loadWe", weSram, 0);
                checkOutput("loadAddr", addr0, loadAddr);
                checkOutput("loadDin", din0, loadData);
            end else begin
                checkOutput("idleCsb", csb0, 1);
                checkOutput("idleWe", weSram, 1);
                checkOutput("idleAddr", addr0, 0);
                checkOutput("idleDin", din0, 0);
            end
        end else begin
            r = expQ[0];
            checkOutput("busyHigh", busy, 1);
            if (r.kind == K_BEAT) begin
                checkOutput("beatReady", ready, 0);
                checkOutput("beatCsb", csb0, 0);
                checkOutput("beatWe", weSram, r.isWrite ? 0 : 1);
                checkOutput("beatAddr", addr0, r.wordAddr);
                if (r.isWrite) begin
                    checkOutput("beatDin", din0, r.din);
                end
            end else if (r.kind == K_DRAIN) begin
                checkOutput("drainReady", ready, 0);
            end else begin
                checkOutput("doneReady", ready, 128'(1) << r.who);
                if (!r.isWrite) begin
                    expRd = lineFromGold(r.line);
                    checkOutput("readLine", rdDataOut, expRd);
                end
            end
        end
    endtask

    // Predicts the effect of the coming clock edge on memory and on the schedule.
    task automatic modelAdvance();
        expRec_t r;
        int winner;
        int line;
        if (expQ.size() > 0) begin
            r = expQ.pop_front();
            if (r.kind == K_BEAT && r.isWrite) begin
                goldMem[r.wordAddr & 255] = r.din;
            end
            if (r.kind == K_DONE) begin
                pending[r.who] = 1'b0;
                active[r.who]  = 1'b0;
            end
        end else if (loadActive) begin
            goldMem[int'(loadAddr) & 255] = loadData;
        end else if (reset) begin
            winner = -1;
            for (int k = 1; k <= N; k++) begin
                if (winner < 0 && req[(modelLast + k) % N]) begin
                    winner = (modelLast + k) % N;
                end
            end
            if (winner >= 0) begin
                modelLast      = winner;
                active[winner] = 1'b1;
                line           = int'(addrIn[winner*AW +: AW] >> 4);
                for (int b = 0; b < 4; b++) begin
                    r.kind     = K_BEAT;
                    r.isWrite  = weLine[winner];
                    r.wordAddr = line*4 + b;
                    r.din      = wrData[winner*128 + b*32 +: 32];
                    r.who      = winner;
                    r.line     = line;
                    expQ.push_back(r);
                end
                if (!r.isWrite) begin
                    r.kind = K_DRAIN;
                    expQ.push_back(r);
                end
                r.kind = K_DONE;
                expQ.push_back(r);
            end
        end
        if (!reset) begin
            expQ.delete();
            modelLast = N - 1;
            expRd     = '0;
            for (int i = 0; i < N; i++) begin
                pending[i] = 1'b0;
                active[i]  = 1'b0;
            end
        end
    endtask

    task automatic runCycle();
        applyStimulus();
        #1;
        modelCheck();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic waitQuiet(input int maxCycles);
        int n = 0;
        while ((expQ.size() > 0 || anyPending()) && n < maxCycles) begin
            runCycle();
            n++;
        end
        checkOutput("quietTimeout", (expQ.size() == 0) && !anyPending(), 1);
    endtask

    initial begin
        reset      = 1'b0;
        req        = '0;
        weLine     = '0;
        addrIn     = '0;
        wrData     = '0;
        loadActive = 1'b0;
        loadAddr   = '0;
        loadData   = '0;
        dout0      = '0;
        expRd      = '0;
        modelLast  = N - 1;
        reqProb    = 0;
        loadProb   = 0;
        dropProb   = 0;
        passCount  = 0;
        checkCount = 0;
        for (int i = 0; i < 256; i++) begin
            sramMem[i] = '0;
            goldMem[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            pending[i] = 1'b0;
            active[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        runCycle();

        startReq(0, 1'b1, 20'h00120, 128'h44444444_33333333_22222222_11111111);
        waitQuiet(20);
        startReq(1, 1'b0, 20'h00120, '0);
        waitQuiet(20);
        checkOutput("readBack", rdDataOut, 128'h44444444_33333333_22222222_11111111);

        reqProb = 100;
        repeat (40) runCycle();
        reqProb = 0;
        waitQuiet(30);

        loadActive = 1'b1;
        loadAddr   = 20'h00005;
        loadData   = 32'hDEADBEEF;
        runCycle();
        loadActive = 1'b0;
        runCycle();

        startReq(0, 1'b0, 20'h00120, '0);
        runCycle();
        for (int c = 0; c < 9; c++) begin
            loadActive = 1'b1;
            loadAddr   = AW'($urandom_range(0, 255));
            loadData   = $urandom;
            runCycle();
        end
        loadActive = 1'b0;
        waitQuiet(20);

        startReq(0, 1'b1, 20'h00340, {$urandom, $urandom, $urandom, $urandom});
        runCycle();
        runCycle();
        runCycle();
        reset = 1'b0;
        runCycle();
        reset = 1'b1;
        runCycle();
        startReq(0, 1'b1, 20'h00350, {$urandom, $urandom, $urandom, $urandom});
        startReq(1, 1'b0, 20'h00350, '0);
        waitQuiet(40);

        reqProb  = 30;
        loadProb = 5;
        dropProb = 20;
        repeat (3000) runCycle();
        reqProb    = 0;
        loadProb   = 0;
        dropProb   = 0;
        loadActive = 1'b0;
        waitQuiet(40);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
